// File: rtl/report_pkg.sv
// report_pkg: scheduler FSM states, header defaults, report lengths and frame-record layout.
package report_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_e;
    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;
    localparam int REPORT_LEN = 9;
    localparam int REPORT_LEN_CSUM = 10;
    localparam int FRAME_W = 56;
    // Record layout: {s_CT[55:48], obs_alert[47:32], max_angle[31:16], min_angle[15:0]}
    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input logic [3:0] i,
                                              input logic [7:0] h0, input logic [7:0] h1);
        case (i)
            4'd0: frame_byte = h0;
            4'd1: frame_byte = h1;
            4'd2: frame_byte = f[55:48];
            4'd3: frame_byte = f[39:32];
            4'd4: frame_byte = f[47:40];
            4'd5: frame_byte = f[23:16];
            4'd6: frame_byte = f[31:24];
            4'd7: frame_byte = f[7:0];
            4'd8: frame_byte = f[15:8];
            default: frame_byte = 8'h00;
        endcase
    endfunction
    function automatic logic [7:0] frame_csum(input logic [FRAME_W-1:0] f);
        frame_csum = f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
    endfunction
endpackage

// File: rtl/report_fifo.sv
// report_fifo: synchronous FIFO of frame records; push while full only succeeds alongside a pop.
module report_fifo import report_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W = FRAME_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [4:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [4:0] count_q;
    logic push_ok, pop_ok;
    assign full_o = count_q == 5'(DEPTH);
    assign empty_o = count_q == 5'd0;
    assign pop_ok = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o = mem_q[rd_q];
    assign count_o = count_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= rd_q + 1'b1;
            count_q <= count_q + 5'(push_ok) - 5'(pop_ok);
        end
    end
endmodule

// File: rtl/report_scheduler.sv
// report_scheduler: buffers frame results and serialises each as a headered UART report.
// Define REPORT_CHECKSUM_EN to append an XOR checksum byte over the seven payload bytes.
module report_scheduler import report_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] HDR0 = HDR0_DEF,
    parameter logic [7:0] HDR1 = HDR1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  s_CT,
    input  logic [15:0] obs_alert,
    input  logic [15:0] max_dist_angle,
    input  logic [15:0] min_dist_angle,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic [4:0]  pending,
    output logic        overflow,
    output logic [7:0]  frame_cnt
);
    state_e state_q;
    logic [FRAME_W-1:0] frame_q, head;
    logic [3:0] idx_q;
    logic [7:0] cur_byte;
    logic fifo_full, fifo_empty, pop;
    assign pop = state_q == S_LOAD;
    report_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(rx_dv),
        .pop_i(pop),
        .data_i({s_CT, obs_alert, max_dist_angle, min_dist_angle}),
        .data_o(head),
        .full_o(fifo_full),
        .empty_o(fifo_empty),
        .count_o(pending)
    );
`ifdef REPORT_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'(REPORT_LEN_CSUM - 1);
    assign cur_byte = (idx_q == LAST) ? frame_csum(frame_q) : frame_byte(frame_q, idx_q, HDR0, HDR1);
`else
    localparam logic [3:0] LAST = 4'(REPORT_LEN - 1);
    assign cur_byte = frame_byte(frame_q, idx_q, HDR0, HDR1);
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            idx_q <= '0;
            tx_start <= 1'b0;
            tx_byte <= 8'h00;
            overflow <= 1'b0;
            frame_cnt <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            if (rx_dv && fifo_full && !pop) overflow <= 1'b1;
            case (state_q)
                // Leave results queued while the UART is busy so a full FIFO really means full.
                S_IDLE: if (!fifo_empty && !tx_busy) state_q <= S_LOAD;
                S_LOAD: begin
                    frame_q <= head;
                    idx_q <= '0;
                    state_q <= S_SEND;
                end
                S_SEND: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    tx_byte <= cur_byte;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (tx_done) begin
                    if (idx_q == LAST) begin
                        state_q <= S_IDLE;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        state_q <= S_SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_report_scheduler.sv
// tb_report_scheduler: scoreboard bench with a UART responder and a byte-level report model.
module tb_report_scheduler;
    localparam int DEPTH = 4;
`ifdef REPORT_CHECKSUM_EN
    localparam int LEN = 10;
`else
    localparam int LEN = 9;
`endif
    typedef struct packed {logic [7:0] b; logic first; logic last;} exp_t;

    logic clk = 0, reset = 1, rx_dv = 0;
    logic [7:0] s_CT = 0;
    logic [15:0] obs_alert = 0, max_dist_angle = 0, min_dist_angle = 0;
    logic hold_busy = 0, uart_busy = 0, uart_done = 0, stray_done = 0;
    logic tx_busy, tx_done, tx_start, overflow;
    logic [7:0] tx_byte, frame_cnt;
    logic [4:0] pending;
    int total = 0, bad = 0, cyc = 0, n_start = 0, rx_cyc = 0, first_start_cyc = 0;
    int end_cyc = 0, fc_model = 0, done_gap = 10, base = 0, t = 0;
    bit have_end = 0, in_flight = 0, cur_last = 0;
    logic [7:0] last_b = 0;
    exp_t expq[$];
    exp_t e;

    assign tx_busy = uart_busy | hold_busy;
    assign tx_done = uart_done | stray_done;

    report_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .s_CT(s_CT), .obs_alert(obs_alert),
        .max_dist_angle(max_dist_angle), .min_dist_angle(min_dist_angle),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_byte(tx_byte),
        .pending(pending), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_report(input logic [7:0] ct, input logic [15:0] al,
                                          input logic [15:0] mx, input logic [15:0] mn);
        logic [7:0] b [10];
        b[0] = 8'hA5; b[1] = 8'h5A; b[2] = ct;
        b[3] = al[7:0]; b[4] = al[15:8];
        b[5] = mx[7:0]; b[6] = mx[15:8];
        b[7] = mn[7:0]; b[8] = mn[15:8];
        b[9] = ct ^ al[7:0] ^ al[15:8] ^ mx[7:0] ^ mx[15:8] ^ mn[7:0] ^ mn[15:8];
        for (int i = 0; i < LEN; i++) expq.push_back('{b[i], i == 0, i == LEN - 1});
        fc_model++;
    endfunction

    task automatic pulse(input logic [7:0] ct, input logic [15:0] al, input logic [15:0] mx,
                         input logic [15:0] mn, input bit ok);
        rx_dv = 1; s_CT = ct; obs_alert = al; max_dist_angle = mx; min_dist_angle = mn;
        rx_cyc = cyc + 1;
        if (ok) expect_report(ct, al, mx, mn);
        align;
        rx_dv = 0;
    endtask

    task automatic rpulse(input bit ok);
        pulse(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), ok);
    endtask

    task automatic do_reset;
        align;
        reset = 1;
        align;
        align;
        reset = 0;
        expq.delete();
        fc_model = 0;
    endtask

    task automatic drain(input string n);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((expq.size() != 0 || in_flight || uart_busy) && k < 5000);
        if (k >= 5000) begin
            total++; bad++;
            $display("FAIL %s_drain: %0d bytes still expected after timeout, want 0", n, expq.size());
        end
        repeat (3) align;
    endtask

    // UART responder: busy after each tx_start, tx_done pulse done_gap cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                uart_busy = 1;
                repeat (done_gap) @(posedge clk);
                #1;
                uart_done = 1;
                uart_busy = 0;
                @(posedge clk);
                #1;
                uart_done = 0;
            end
        end
    end

    // Monitor: every tx_start pops and checks the next expected byte
    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0;
            have_end = 0;
        end else begin
            if (uart_done && in_flight) begin
                chk("tx_byte_stable", tx_byte, last_b);
                in_flight = 0;
                if (cur_last) begin
                    end_cyc = cyc + 1;
                    have_end = 1;
                end
            end
            if (tx_start) begin
                n_start++;
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: got tx_start with byte %02h, expected none", tx_byte);
                end else begin
                    e = expq.pop_front();
                    chk("tx_byte", tx_byte, e.b);
                    if (e.first) begin
                        first_start_cyc = cyc;
                        if (have_end) chk("b2b_gap_ge3", 32'(cyc - end_cyc >= 3), 1);
                    end
                    cur_last = e.last;
                    last_b = e.b;
                    in_flight = 1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        align;
        reset = 0;
        fc_model = 0;

        align; stray_done = 1; align; stray_done = 0;
        repeat (6) align;
        chk("idle_stray_no_start", n_start, 0);

        done_gap = 10;
        pulse(8'h08, 16'h00F1, 16'h1234, 16'h0ABC, 1);
        drain("single");
        chk("latency", first_start_cyc - rx_cyc, 3);
        chk("frame_cnt_single", frame_cnt, 1);

        base = n_start;
        rpulse(1);
        t = 0;
        while (n_start == base && t < 100) begin @(negedge clk); t++; end
        hold_busy = 1;
        repeat (15) align;
        stray_done = 1; align; stray_done = 0; align;
        stray_done = 1; align; stray_done = 0;
        repeat (3) align;
        chk("send_stray_no_start", n_start, base + 1);
        hold_busy = 0;
        drain("send_stray");
        chk("send_stray_count", n_start, base + LEN);
        chk("frame_cnt_two", frame_cnt, 2);

        do_reset;
        hold_busy = 1;
        align;
        for (int i = 0; i < 5; i++) rpulse(i < 4);
        @(negedge clk);
        chk("ovf_pending", pending, 4);
        chk("ovf_flag", overflow, 1);
        align;
        hold_busy = 0;
        drain("overflow");
        chk("ovf_frame_cnt", frame_cnt, 4);
        chk("ovf_sticky", overflow, 1);

        do_reset;
        hold_busy = 1;
        align;
        for (int i = 0; i < 4; i++) rpulse(1);
        hold_busy = 0;
        align;
        rpulse(1);
        @(negedge clk);
        chk("full_pushpop_pending", pending, 4);
        chk("full_pushpop_overflow", overflow, 0);
        drain("full_pushpop");
        chk("full_pushpop_frame_cnt", frame_cnt, 5);

        do_reset;
        base = n_start;
        rpulse(1);
        t = 0;
        while (n_start < base + 4 && t < 200) begin @(negedge clk); t++; end
        align;
        reset = 1;
        expq.delete();
        fc_model = 0;
        align;
        reset = 0;
        repeat (20) @(negedge clk);
        chk("abort_no_start", n_start, base + 4);
        chk("abort_tx_start", tx_start, 0);
        chk("abort_pending", pending, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        align;
        rpulse(1);
        drain("after_abort");
        chk("after_abort_frame_cnt", frame_cnt, 1);

        do_reset;
        for (int k = 0; k < 60; k++) begin
            done_gap = $urandom_range(1, 4);
            hold_busy = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 6)) align;
            t = 0;
            while (expq.size() > (DEPTH - 1) * LEN && t < 2000) begin
                hold_busy = 0;
                align;
                t++;
            end
            rpulse(1);
        end
        hold_busy = 0;
        drain("random");
        chk("random_frame_cnt", frame_cnt, 32'(fc_model[7:0]));
        chk("random_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
